pipe_reg_stage: RTL and testbench

//   Parametrised pipeline register with valid/ready handshake, synchronous flush and an

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_stage_ctrl.sv | 89 ++++++++
 rtl/pipe_reg_stage.sv | 75 +++++++
 tb/tb_pipe_reg_stage.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline-stage state encoding
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef enum logic [1:0] {
        STATE_EMPTY = ST_EMPTY,
        STATE_BUSY  = ST_BUSY,
        STATE_FULL  = ST_FULL
    } pipe_state_e;

endpackage

// File: rtl/pipe_stage_ctrl.sv
// rtl/pipe_stage_ctrl.sv - occupancy FSM, handshake outputs and payload load enables
module pipe_stage_ctrl
    import pipe_pkg::*;
#(
    parameter int SKID = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_valid,
    input  logic out_ready,
    output logic in_ready,
    output logic out_valid,
    output logic main_load,
    output logic skid_load,
    output logic main_from_skid
);

    pipe_state_e state_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic        in_fire;
    logic        out_fire;

    // Without a skid entry the stage can only accept when its one entry leaves now.
    assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid_q | out_ready);
    assign out_valid = out_valid_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid_q & out_ready;

    always_comb begin
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        if (!rst && !flush) begin
            case (state_q)
                STATE_EMPTY: main_load = in_fire;
                STATE_BUSY: begin
                    main_load = in_fire & out_fire;
                    skid_load = in_fire & !out_fire & (SKID != 0);
                end
                STATE_FULL:  main_from_skid = out_fire;
                default:     main_load = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q     <= STATE_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                STATE_EMPTY: begin
                    if (in_fire) begin
                        state_q     <= STATE_BUSY;
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                    end
                end
                STATE_BUSY: begin
                    if (in_fire && !out_fire && (SKID != 0)) begin
                        state_q     <= STATE_FULL;
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b0;
                    end else if (out_fire && !in_fire) begin
                        state_q     <= STATE_EMPTY;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                STATE_FULL: begin
                    if (out_fire) begin
                        state_q     <= STATE_BUSY;
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= STATE_EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_reg_stage.sv
// rtl/pipe_reg_stage.sv - valid/ready pipeline register with flush and optional skid entry
module pipe_reg_stage
    import pipe_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               SKID        = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             main_load;
    logic             skid_load;
    logic             main_from_skid;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_data;

    pipe_stage_ctrl #(
        .SKID(SKID)
    ) u_ctrl (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .out_ready      (out_ready),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .main_load      (main_load),
        .skid_load      (skid_load),
        .main_from_skid (main_from_skid)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic [WIDTH-1:0] skid_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    skid_q <= RESET_VALUE;
                end else if (skid_load) begin
                    skid_q <= in_data;
                end
            end

            assign skid_data = skid_q;
        end else begin : g_no_skid
            logic skid_load_unused;

            assign skid_load_unused = skid_load;
            assign skid_data        = main_q;
        end
    endgenerate

    // Flush leaves the payload alone; only out_valid tells consumers it is stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= RESET_VALUE;
        end else if (main_load) begin
            main_q <= in_data;
        end else if (main_from_skid) begin
            main_q <= skid_data;
        end
    end

    assign out_data = main_q;

endmodule

// File: tb/tb_pipe_reg_stage.sv
// tb/tb_pipe_reg_stage.sv - directed and scoreboard bench for pipe_reg_stage in both skid modes
module tb_pipe_reg_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush1 = 1'b0, flush0 = 1'b0;
    logic        in_valid1 = 1'b0, in_valid0 = 1'b0;
    logic        in_ready1, in_ready0;
    logic [31:0] in_data1 = '0, in_data0 = '0;
    logic        out_valid1, out_valid0;
    logic        out_ready1 = 1'b0, out_ready0 = 1'b0;
    logic [31:0] out_data1, out_data0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_reg_stage #(.WIDTH(32), .RESET_VALUE(32'hDEADBEEF), .SKID(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1)
    );

    pipe_reg_stage #(.WIDTH(32), .RESET_VALUE(32'h00005A5A), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush0),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0)
    );

    assert property (@(posedge clk) disable iff (rst)
        (out_valid1 && !out_ready1 && !flush1) |=> (out_valid1 && $stable(out_data1)))
        else $error("FAIL hold_assert_skid1");
    assert property (@(posedge clk) disable iff (rst)
        (out_valid0 && !out_ready0 && !flush0) |=> (out_valid0 && $stable(out_data0)))
        else $error("FAIL hold_assert_skid0");

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++; if (out_valid1 !== 1'b0) begin bad++; $display("FAIL reset_out_valid1 got %b want 0", out_valid1); end
        total++; if (out_data1 !== 32'hDEADBEEF) begin bad++; $display("FAIL reset_out_data1 got %h want deadbeef", out_data1); end
        total++; if (in_ready1 !== 1'b1) begin bad++; $display("FAIL reset_in_ready1 got %b want 1", in_ready1); end
        total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL reset_out_valid0 got %b want 0", out_valid0); end
        total++; if (out_data0 !== 32'h00005A5A) begin bad++; $display("FAIL reset_out_data0 got %h want 00005a5a", out_data0); end
        total++; if (in_ready0 !== 1'b1) begin bad++; $display("FAIL reset_in_ready0 got %b want 1", in_ready0); end
        rst = 1'b0;
        step();
        total++; if (out_valid1 !== 1'b0) begin bad++; $display("FAIL idle_out_valid1 got %b want 0", out_valid1); end
    endtask

    task automatic test_streaming();
        out_ready1 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid1 = 1'b1;
            in_data1  = i;
            #1;
            total++; if (in_ready1 !== 1'b1) begin bad++; $display("FAIL stream_in_ready[%0d] got %b want 1", i, in_ready1); end
            step();
            total++; if (out_valid1 !== 1'b1) begin bad++; $display("FAIL stream_out_valid[%0d] got %b want 1", i, out_valid1); end
            total++; if (out_data1 !== 32'(i)) begin bad++; $display("FAIL stream_out_data[%0d] got %h want %h", i, out_data1, 32'(i)); end
        end
        in_valid1 = 1'b0;
        step();
        total++; if (out_valid1 !== 1'b0) begin bad++; $display("FAIL stream_drain_out_valid got %b want 0", out_valid1); end
        out_ready1 = 1'b0;
    endtask

    task automatic fill_a_b();
        out_ready1 = 1'b0;
        in_valid1  = 1'b1;
        in_data1   = 32'hA;
        step();
        in_data1   = 32'hB;
        step();
        in_valid1  = 1'b0;
    endtask

    task automatic test_backpressure();
        fill_a_b();
        total++; if (in_ready1 !== 1'b0) begin bad++; $display("FAIL bp_full_in_ready got %b want 0", in_ready1); end
        total++; if (out_valid1 !== 1'b1) begin bad++; $display("FAIL bp_full_out_valid got %b want 1", out_valid1); end
        total++; if (out_data1 !== 32'hA) begin bad++; $display("FAIL bp_full_out_data got %h want 0000000a", out_data1); end
        // push while not ready must be ignored
        in_valid1 = 1'b1;
        in_data1  = 32'hEE;
        step();
        in_valid1 = 1'b0;
        total++; if (out_data1 !== 32'hA) begin bad++; $display("FAIL bp_violation_out_data got %h want 0000000a", out_data1); end
        total++; if (in_ready1 !== 1'b0) begin bad++; $display("FAIL bp_violation_in_ready got %b want 0", in_ready1); end
        out_ready1 = 1'b1;
        #1;
        total++; if (out_data1 !== 32'hA) begin bad++; $display("FAIL bp_emit_first got %h want 0000000a", out_data1); end
        step();
        total++; if (out_data1 !== 32'hB || out_valid1 !== 1'b1) begin bad++; $display("FAIL bp_emit_second got %h/%b want 0000000b/1", out_data1, out_valid1); end
        total++; if (in_ready1 !== 1'b1) begin bad++; $display("FAIL bp_in_ready_back got %b want 1", in_ready1); end
        step();
        total++; if (out_valid1 !== 1'b0) begin bad++; $display("FAIL bp_empty_out_valid got %b want 0", out_valid1); end
        out_ready1 = 1'b0;
    endtask

    task automatic test_flush();
        fill_a_b();
        flush1    = 1'b1;
        in_valid1 = 1'b1;
        in_data1  = 32'hC;
        step();
        flush1    = 1'b0;
        in_valid1 = 1'b0;
        total++; if (out_valid1 !== 1'b0) begin bad++; $display("FAIL flush_full_out_valid got %b want 0", out_valid1); end
        total++; if (in_ready1 !== 1'b1) begin bad++; $display("FAIL flush_full_in_ready got %b want 1", in_ready1); end
        total++; if (out_data1 !== 32'hA) begin bad++; $display("FAIL flush_payload_kept got %h want 0000000a", out_data1); end
        out_ready1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (out_valid1 !== 1'b0 || out_data1 === 32'hC) begin bad++; $display("FAIL flush_no_c[%0d] got %b/%h want 0/not c", i, out_valid1, out_data1); end
        end
        out_ready1 = 1'b0;
        in_valid1  = 1'b1;
        in_data1   = 32'hD;
        step();
        flush1     = 1'b1;
        in_data1   = 32'hE;
        step();
        flush1     = 1'b0;
        in_valid1  = 1'b0;
        total++; if (out_valid1 !== 1'b0 || out_data1 !== 32'hD) begin bad++; $display("FAIL flush_busy_drop got %b/%h want 0/0000000d", out_valid1, out_data1); end
        step();
        total++; if (out_valid1 !== 1'b0) begin bad++; $display("FAIL flush_busy_stays_empty got %b want 0", out_valid1); end
    endtask

    task automatic test_skid0();
        out_ready0 = 1'b0;
        in_valid0  = 1'b1;
        in_data0   = 32'h11;
        step();
        in_data0   = 32'h22;
        #1;
        total++; if (out_valid0 !== 1'b1 || out_data0 !== 32'h11) begin bad++; $display("FAIL s0_busy got %b/%h want 1/00000011", out_valid0, out_data0); end
        total++; if (in_ready0 !== 1'b0) begin bad++; $display("FAIL s0_in_ready_blocked got %b want 0", in_ready0); end
        step();
        total++; if (out_data0 !== 32'h11) begin bad++; $display("FAIL s0_violation_ignored got %h want 00000011", out_data0); end
        out_ready0 = 1'b1;
        #1;
        total++; if (in_ready0 !== 1'b1) begin bad++; $display("FAIL s0_in_ready_comb got %b want 1", in_ready0); end
        step();
        in_valid0 = 1'b0;
        total++; if (out_valid0 !== 1'b1 || out_data0 !== 32'h22) begin bad++; $display("FAIL s0_pass_through got %b/%h want 1/00000022", out_valid0, out_data0); end
        step();
        total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL s0_empty got %b want 0", out_valid0); end
        out_ready0 = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] q1[$];
        logic [31:0] q0[$];
        logic        hold1 = 1'b0, hold0 = 1'b0;
        logic [31:0] held1 = '0, held0 = '0;
        logic [31:0] exp;
        int          n = 10000;
        for (int c = 0; c < n + 6; c++) begin
            step();
            if (c < n) begin
                in_valid1  = ($urandom_range(0, 3) != 0);
                in_data1   = $urandom;
                out_ready1 = ($urandom_range(0, 2) != 0);
                in_valid0  = ($urandom_range(0, 3) != 0);
                in_data0   = $urandom;
                out_ready0 = ($urandom_range(0, 2) != 0);
            end else begin
                in_valid1 = 1'b0; out_ready1 = 1'b1;
                in_valid0 = 1'b0; out_ready0 = 1'b1;
            end
            #1;
            total++; if (out_valid1 !== (q1.size() != 0)) begin bad++; $display("FAIL rnd1_out_valid c=%0d got %b want %b", c, out_valid1, q1.size() != 0); end
            total++; if (in_ready1 !== (q1.size() < 2)) begin bad++; $display("FAIL rnd1_in_ready c=%0d got %b want %b", c, in_ready1, q1.size() < 2); end
            total++; if (out_valid0 !== (q0.size() != 0)) begin bad++; $display("FAIL rnd0_out_valid c=%0d got %b want %b", c, out_valid0, q0.size() != 0); end
            total++; if (in_ready0 !== (q0.size() == 0 || out_ready0)) begin bad++; $display("FAIL rnd0_in_ready c=%0d got %b want %b", c, in_ready0, q0.size() == 0 || out_ready0); end
            if (hold1) begin
                total++; if (out_data1 !== held1) begin bad++; $display("FAIL rnd1_hold c=%0d got %h want %h", c, out_data1, held1); end
            end
            if (hold0) begin
                total++; if (out_data0 !== held0) begin bad++; $display("FAIL rnd0_hold c=%0d got %h want %h", c, out_data0, held0); end
            end
            if (out_valid1 && out_ready1 && q1.size() != 0) begin
                exp = q1.pop_front();
                total++; if (out_data1 !== exp) begin bad++; $display("FAIL rnd1_order c=%0d got %h want %h", c, out_data1, exp); end
            end
            if (out_valid0 && out_ready0 && q0.size() != 0) begin
                exp = q0.pop_front();
                total++; if (out_data0 !== exp) begin bad++; $display("FAIL rnd0_order c=%0d got %h want %h", c, out_data0, exp); end
            end
            if (in_valid1 && in_ready1) q1.push_back(in_data1);
            if (in_valid0 && in_ready0) q0.push_back(in_data0);
            hold1 = out_valid1 && !out_ready1;
            held1 = out_data1;
            hold0 = out_valid0 && !out_ready0;
            held0 = out_data0;
        end
        total++; if (q1.size() != 0 || out_valid1 !== 1'b0) begin bad++; $display("FAIL rnd1_drained left=%0d out_valid=%b want 0/0", q1.size(), out_valid1); end
        total++; if (q0.size() != 0 || out_valid0 !== 1'b0) begin bad++; $display("FAIL rnd0_drained left=%0d out_valid=%b want 0/0", q0.size(), out_valid0); end
        in_valid1 = 1'b0; out_ready1 = 1'b0;
        in_valid0 = 1'b0; out_ready0 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_skid0();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
